// File: rtl/voxel_stream_loader.sv
// Framed UART byte stream to voxel cache loader: full-world sweep or single
// addressed voxel update, with sticky range/timeout/overflow error flags.
module voxel_stream_loader #(
    parameter int          LENGTH         = 64,
    parameter int          WIDTH          = 64,
    parameter int          HEIGHT         = 16,
    parameter int          BLOCK_BITS     = 5,
    parameter logic [7:0]  SYNC_BYTE      = 8'hA5,
    parameter int          TIMEOUT_CYCLES = 1_000_000
) (
    input  logic                      clk_in,
    input  logic                      rst_in,
    input  logic [7:0]                byte_in,
    input  logic                      byte_valid_in,
    input  logic                      wr_ready_in,
    input  logic                      clr_err_in,
    output logic                      wr_valid_out,
    output logic [$clog2(LENGTH)-1:0] wr_x_out,
    output logic [$clog2(WIDTH)-1:0]  wr_y_out,
    output logic [$clog2(HEIGHT)-1:0] wr_z_out,
    output logic [BLOCK_BITS-1:0]     wr_data_out,
    output logic                      busy_out,
    output logic                      loaded_out,
    output logic                      done_out,
    output logic [2:0]                err_out
);
    localparam int BPB = (BLOCK_BITS + 7) / 8;
    localparam int XW  = $clog2(LENGTH);
    localparam int YW  = $clog2(WIDTH);
    localparam int ZW  = $clog2(HEIGHT);
    localparam int CW  = (BPB > 1) ? $clog2(BPB) : 1;
    localparam int TW  = $clog2(TIMEOUT_CYCLES + 1);

    localparam logic [XW-1:0] X_LAST   = XW'(LENGTH - 1);
    localparam logic [YW-1:0] Y_LAST   = YW'(WIDTH - 1);
    localparam logic [ZW-1:0] Z_LAST   = ZW'(HEIGHT - 1);
    localparam logic [CW-1:0] CNT_LAST = CW'(BPB - 1);
    localparam logic [TW-1:0] GAP_LAST = TW'(TIMEOUT_CYCLES - 1);

    // S_FIN holds the frame open until the final sweep write is accepted
    typedef enum logic [2:0] {
        S_IDLE, S_MODE, S_LOAD, S_COORD, S_DATA, S_FIN
    } state_t;

    state_t              state_reg, state_next;
    logic [CW-1:0]       byte_cnt_reg, byte_cnt_next;
    logic [7:0]          byte_buf [BPB];
    logic [XW-1:0]       x_reg, x_next, cx_reg, cx_next, wr_x_reg, wr_x_next;
    logic [YW-1:0]       y_reg, y_next, cy_reg, cy_next, wr_y_reg, wr_y_next;
    logic [ZW-1:0]       z_reg, z_next, cz_reg, cz_next, wr_z_reg, wr_z_next;
    logic [1:0]          coord_idx_reg, coord_idx_next;
    logic                bad_reg, bad_next;
    logic                wr_valid_reg, wr_valid_next;
    logic [BLOCK_BITS-1:0] wr_data_reg, wr_data_next;
    logic                loaded_reg, loaded_next;
    logic                done_reg, done_next;
    logic [2:0]          err_reg, err_next;
    logic [TW-1:0]       gap_reg, gap_next;

    logic                data_state, stall, data_byte, drop, take, voxel_done;
    logic                last_voxel, timeout_hit, coord_bad;
    logic [8*BPB-1:0]    voxel_word;
    logic                unused_bits;

    // Little-endian assembly; the final byte comes straight from the input
    for (genvar gi = 0; gi < BPB; gi++) begin : g_word
        if (gi == BPB - 1) begin : g_last
            assign voxel_word[gi*8 +: 8] = byte_in;
        end else begin : g_buf
            assign voxel_word[gi*8 +: 8] = byte_buf[gi];
        end
    end
    assign unused_bits = ^{voxel_word, byte_buf[BPB-1]};

    assign data_state  = (state_reg == S_LOAD) || (state_reg == S_DATA);
    assign stall       = wr_valid_reg && !wr_ready_in;
    assign data_byte   = byte_valid_in && data_state;
    assign drop        = data_byte && stall;
    assign take        = data_byte && !stall;
    assign voxel_done  = take && (byte_cnt_reg == CNT_LAST);
    assign last_voxel  = (x_reg == X_LAST) && (y_reg == Y_LAST) && (z_reg == Z_LAST);
    assign timeout_hit = (state_reg != S_IDLE) && !byte_valid_in && (gap_reg == GAP_LAST);

    always_comb begin
        unique case (coord_idx_reg)
            2'd0:    coord_bad = int'(byte_in) >= LENGTH;
            2'd1:    coord_bad = int'(byte_in) >= WIDTH;
            default: coord_bad = int'(byte_in) >= HEIGHT;
        endcase
    end

    always_comb begin
        state_next     = state_reg;
        byte_cnt_next  = byte_cnt_reg;
        x_next         = x_reg;
        y_next         = y_reg;
        z_next         = z_reg;
        cx_next        = cx_reg;
        cy_next        = cy_reg;
        cz_next        = cz_reg;
        coord_idx_next = coord_idx_reg;
        bad_next       = bad_reg;
        wr_valid_next  = wr_valid_reg && !wr_ready_in;
        wr_x_next      = wr_x_reg;
        wr_y_next      = wr_y_reg;
        wr_z_next      = wr_z_reg;
        wr_data_next   = wr_data_reg;
        loaded_next    = loaded_reg;
        done_next      = 1'b0;
        err_next       = clr_err_in ? 3'b000 : err_reg;
        gap_next       = (state_reg == S_IDLE || byte_valid_in) ? '0 : gap_reg + TW'(1);

        if (drop)
            err_next[0] = 1'b1;
        if (take)
            byte_cnt_next = (byte_cnt_reg == CNT_LAST) ? '0 : byte_cnt_reg + CW'(1);

        unique case (state_reg)
            S_IDLE: begin
                if (byte_valid_in && byte_in == SYNC_BYTE)
                    state_next = S_MODE;
            end
            S_MODE: begin
                if (byte_valid_in) begin
                    if (byte_in == 8'h00) begin
                        state_next    = S_LOAD;
                        loaded_next   = 1'b0;
                        x_next        = '0;
                        y_next        = '0;
                        z_next        = '0;
                        byte_cnt_next = '0;
                    end else if (byte_in == 8'h01) begin
                        state_next     = S_COORD;
                        coord_idx_next = 2'd0;
                        bad_next       = 1'b0;
                    end else begin
                        state_next = S_IDLE;
                    end
                end
            end
            S_LOAD: begin
                if (voxel_done) begin
                    wr_valid_next = 1'b1;
                    wr_x_next     = x_reg;
                    wr_y_next     = y_reg;
                    wr_z_next     = z_reg;
                    wr_data_next  = voxel_word[BLOCK_BITS-1:0];
                    if (last_voxel) begin
                        state_next = S_FIN;
                    end else if (x_reg != X_LAST) begin
                        x_next = x_reg + XW'(1);
                    end else begin
                        x_next = '0;
                        if (y_reg != Y_LAST) begin
                            y_next = y_reg + YW'(1);
                        end else begin
                            y_next = '0;
                            z_next = z_reg + ZW'(1);
                        end
                    end
                end
            end
            S_COORD: begin
                if (byte_valid_in) begin
                    if (coord_bad) begin
                        bad_next    = 1'b1;
                        err_next[2] = 1'b1;
                    end
                    unique case (coord_idx_reg)
                        2'd0:    cx_next = byte_in[XW-1:0];
                        2'd1:    cy_next = byte_in[YW-1:0];
                        default: cz_next = byte_in[ZW-1:0];
                    endcase
                    coord_idx_next = coord_idx_reg + 2'd1;
                    if (coord_idx_reg == 2'd2) begin
                        state_next    = S_DATA;
                        byte_cnt_next = '0;
                    end
                end
            end
            S_DATA: begin
                if (voxel_done) begin
                    state_next = S_IDLE;
                    if (!bad_reg) begin
                        wr_valid_next = 1'b1;
                        wr_x_next     = cx_reg;
                        wr_y_next     = cy_reg;
                        wr_z_next     = cz_reg;
                        wr_data_next  = voxel_word[BLOCK_BITS-1:0];
                    end
                end
            end
            S_FIN: begin
                if (wr_valid_reg && wr_ready_in) begin
                    done_next   = 1'b1;
                    loaded_next = 1'b1;
                    state_next  = S_IDLE;
                end
            end
            default: state_next = S_IDLE;
        endcase

        if (timeout_hit) begin
            err_next[1] = 1'b1;
            state_next  = S_IDLE;
        end
    end

    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            state_reg     <= S_IDLE;
            byte_cnt_reg  <= '0;
            x_reg         <= '0;
            y_reg         <= '0;
            z_reg         <= '0;
            cx_reg        <= '0;
            cy_reg        <= '0;
            cz_reg        <= '0;
            coord_idx_reg <= '0;
            bad_reg       <= 1'b0;
            wr_valid_reg  <= 1'b0;
            wr_x_reg      <= '0;
            wr_y_reg      <= '0;
            wr_z_reg      <= '0;
            wr_data_reg   <= '0;
            loaded_reg    <= 1'b0;
            done_reg      <= 1'b0;
            err_reg       <= '0;
            gap_reg       <= '0;
            for (int i = 0; i < BPB; i++)
                byte_buf[i] <= '0;
        end else begin
            state_reg     <= state_next;
            byte_cnt_reg  <= byte_cnt_next;
            x_reg         <= x_next;
            y_reg         <= y_next;
            z_reg         <= z_next;
            cx_reg        <= cx_next;
            cy_reg        <= cy_next;
            cz_reg        <= cz_next;
            coord_idx_reg <= coord_idx_next;
            bad_reg       <= bad_next;
            wr_valid_reg  <= wr_valid_next;
            wr_x_reg      <= wr_x_next;
            wr_y_reg      <= wr_y_next;
            wr_z_reg      <= wr_z_next;
            wr_data_reg   <= wr_data_next;
            loaded_reg    <= loaded_next;
            done_reg      <= done_next;
            err_reg       <= err_next;
            gap_reg       <= gap_next;
            if (take)
                byte_buf[byte_cnt_reg] <= byte_in;
        end
    end

    assign wr_valid_out = wr_valid_reg;
    assign wr_x_out     = wr_x_reg;
    assign wr_y_out     = wr_y_reg;
    assign wr_z_out     = wr_z_reg;
    assign wr_data_out  = wr_data_reg;
    assign busy_out     = (state_reg != S_IDLE);
    assign loaded_out   = loaded_reg;
    assign done_out     = done_reg;
    assign err_out      = err_reg;
endmodule
